// File: rtl/lzss_encoder.sv
// lzss_encoder: streaming LZSS compressor emitting literal/match tokens over a valid/ready handshake
package lzss_pkg;
    parameter int SYMBOL_LENGTH      = 8;
    parameter int SEARCH_BUFFER_SIZE = 8;
endpackage

module lzss_encoder
    import lzss_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_,
    input  logic [SYMBOL_LENGTH-1:0]   sym_in,
    input  logic                       sym_valid,
    input  logic                       sym_last,
    output logic                       in_ready,
    output logic                       token_valid,
    input  logic                       token_ready,
    output logic                       literal,
    output logic [3*SYMBOL_LENGTH-1:0] data_out,
    output logic                       done
);
    localparam int LOOKAHEAD_SIZE = 16;
    localparam int MIN_MATCH      = 3;
    localparam int DW             = 3 * SYMBOL_LENGTH;
    localparam int CW             = $clog2(LOOKAHEAD_SIZE + 1);
    localparam int LW             = $clog2(LOOKAHEAD_SIZE);
    localparam int HW             = $clog2(SEARCH_BUFFER_SIZE + 1);
    localparam int IW             = $clog2(SEARCH_BUFFER_SIZE);

    typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_t;

    state_t                   state, state_nx;
    logic [SYMBOL_LENGTH-1:0] la   [LOOKAHEAD_SIZE];
    logic [SYMBOL_LENGTH-1:0] hist [SEARCH_BUFFER_SIZE];
    logic [CW-1:0]            la_cnt;
    logic [HW-1:0]            hist_cnt;
    logic [IW-1:0]            off, best_off;
    logic [7:0]               best_len, cur_len, shift_cnt;
    logic                     last_seen, live, run;
    logic                     accept, search_end, is_match;

    assign accept     = sym_valid && in_ready;
    assign search_end = (hist_cnt == '0) || (HW'(off) + HW'(1) >= hist_cnt);
    assign is_match   = best_len >= 8'(MIN_MATCH);

    // Match length at the current offset; la_cnt never exceeds 255, which also enforces the 255 cap
    always_comb begin
        cur_len = '0;
        run     = hist_cnt != '0;
        for (int k = 0; k < LOOKAHEAD_SIZE; k++) begin
            if (run && k <= int'(off) && k < int'(la_cnt) && la[k] == hist[off - IW'(k)])
                cur_len = cur_len + 8'd1;
            else
                run = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            FILL: begin
                if (la_cnt == CW'(LOOKAHEAD_SIZE) || (last_seen && la_cnt != '0))
                    state_nx = SEARCH;
                else if (last_seen)
                    state_nx = DONE;
            end
            SEARCH:  state_nx = search_end ? EMIT : SEARCH;
            EMIT:    state_nx = token_ready ? SHIFT : EMIT;
            SHIFT:   state_nx = (shift_cnt == 8'd1) ? FILL : SHIFT;
            DONE:    state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    // Outputs decode from registered state only, so reset clears them without waiting for a clock
    always_comb begin
        in_ready    = live && state == FILL && la_cnt < CW'(LOOKAHEAD_SIZE) && !last_seen;
        token_valid = state == EMIT;
        literal     = state == EMIT && !is_match;
        data_out    = state != EMIT ? '0 :
                      is_match      ? DW'({best_len, 16'(best_off)}) : DW'(la[0]);
        done        = state == DONE;
    end

    // Control state, counters and search bookkeeping
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state     <= FILL;
            la_cnt    <= '0;
            hist_cnt  <= '0;
            off       <= '0;
            best_off  <= '0;
            best_len  <= '0;
            shift_cnt <= '0;
            last_seen <= 1'b0;
            live      <= 1'b0;
        end else begin
            state <= state_nx;
            live  <= 1'b1;
            if (accept) begin
                la_cnt <= la_cnt + CW'(1);
                if (sym_last)
                    last_seen <= 1'b1;
            end
            if (state == FILL && state_nx == SEARCH) begin
                off      <= '0;
                best_off <= '0;
                best_len <= '0;
            end
            if (state == SEARCH) begin
                if (cur_len > best_len) begin
                    best_len <= cur_len;
                    best_off <= off;
                end
                off <= off + IW'(1);
            end
            if (state == EMIT && token_ready)
                shift_cnt <= is_match ? best_len : 8'd1;
            if (state == SHIFT) begin
                shift_cnt <= shift_cnt - 8'd1;
                la_cnt    <= la_cnt - CW'(1);
                if (hist_cnt != HW'(SEARCH_BUFFER_SIZE))
                    hist_cnt <= hist_cnt + HW'(1);
            end
            if (state == DONE) begin
                last_seen <= 1'b0;
                hist_cnt  <= '0;
            end
        end
    end

    // Symbol storage: append to the lookahead tail, and in SHIFT move the head into history entry 0
    always_ff @(posedge clk) begin
        if (accept)
            la[la_cnt[LW-1:0]] <= sym_in;
        if (state == SHIFT) begin
            for (int k = 0; k < LOOKAHEAD_SIZE - 1; k++)
                la[k] <= la[k+1];
            hist[0] <= la[0];
            for (int k = 1; k < SEARCH_BUFFER_SIZE; k++)
                hist[k] <= hist[k-1];
        end
    end
endmodule

// File: tb/tb_lzss_encoder.sv
// tb_lzss_encoder: scoreboard bench comparing the encoder against a back-reference model of LZSS
module tb_lzss_encoder;
    localparam int L = 16;
    localparam int S = 8;

    typedef struct packed {
        logic        d;
        logic        lit;
        logic [23:0] data;
    } tok_t;

    logic        clk = 1'b0, rst_ = 1'b0;
    logic [7:0]  sym_in = '0;
    logic        sym_valid = 1'b0, sym_last = 1'b0, token_ready = 1'b0;
    logic        in_ready, token_valid, literal, done;
    logic [23:0] data_out;

    tok_t exp_q[$];
    int   vectors = 0, miscompares = 0;
    bit   hold = 1'b1;

    lzss_encoder dut (
        .clk(clk), .rst_(rst_), .sym_in(sym_in), .sym_valid(sym_valid), .sym_last(sym_last),
        .in_ready(in_ready), .token_valid(token_valid), .token_ready(token_ready),
        .literal(literal), .data_out(data_out), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic push_lits(input string s);
        for (int i = 0; i < s.len(); i++)
            exp_q.push_back('{d: 1'b0, lit: 1'b1, data: 24'(s[i])});
    endtask

    task automatic push_match(input int len, input int offset);
        exp_q.push_back('{d: 1'b0, lit: 1'b0, data: {8'(len), 16'(offset)}});
    endtask

    task automatic push_done();
        exp_q.push_back('{d: 1'b1, lit: 1'b0, data: 24'h0});
    endtask

    // A history entry at offset d is the symbol d+1 places before the current position
    task automatic model(input logic [7:0] s[$]);
        int pos;
        pos = 0;
        while (pos < s.size()) begin
            int cnt, hc, best, boff, len;
            cnt  = (s.size() - pos < L) ? s.size() - pos : L;
            hc   = (pos < S) ? pos : S;
            best = 0;
            boff = 0;
            for (int d = 0; d < hc; d++) begin
                len = 0;
                while (len <= d && len < cnt && s[pos+len] == s[pos-1-d+len])
                    len++;
                if (len > best) begin
                    best = len;
                    boff = d;
                end
            end
            if (best >= 3)
                push_match(best, boff);
            else begin
                exp_q.push_back('{d: 1'b0, lit: 1'b1, data: 24'(s[pos])});
                best = 1;
            end
            pos += best;
        end
        push_done();
    endtask

    task automatic send(input logic [7:0] s[$]);
        for (int i = 0; i < s.size(); i++) begin
            int n;
            n = 0;
            @(negedge clk);
            sym_valid = 1'b1;
            sym_in    = s[i];
            sym_last  = (i == s.size() - 1);
            while (!in_ready && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                fail("in_ready_timeout");
                sym_valid = 1'b0;
                sym_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            sym_valid = 1'b0;
            sym_last  = 1'b0;
        end
    endtask

    task automatic send_str(input string s);
        logic [7:0] q[$];
        for (int i = 0; i < s.len(); i++)
            q.push_back(8'(s[i]));
        send(q);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail("drain_timeout");
            exp_q.delete();
        end
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!token_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!token_valid)
            fail("token_valid_timeout");
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_token_valid"}, token_valid, 0);
        chk({tag, "_literal"}, literal, 0);
        chk({tag, "_data_out"}, data_out, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        chk("in_ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", in_ready, 1);
    endtask

    // Monitor: drives token_ready and checks every transfer and done pulse against the scoreboard
    initial forever begin
        @(negedge clk);
        token_ready = !hold && ($urandom_range(0, 3) != 0);
        if (rst_) begin
            if (token_valid)
                chk("in_ready_while_token", in_ready, 0);
            if (token_valid && token_ready) begin
                if (exp_q.size() == 0 || exp_q[0].d)
                    fail("unexpected_token");
                else begin
                    chk("token_literal", literal, exp_q[0].lit);
                    chk("token_data", data_out, exp_q[0].data);
                    void'(exp_q.pop_front());
                end
            end
            if (done) begin
                if (exp_q.size() == 0 || !exp_q[0].d)
                    fail("unexpected_done");
                else begin
                    vectors++;
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d0;
        logic        l0;
        #3;
        chk_idle("reset");
        release_reset();
        hold = 1'b0;

        push_lits("ABC"); push_done();
        send_str("ABC"); drain();

        push_lits("ABC"); push_match(3, 2); push_done();
        send_str("ABCABC"); drain();

        push_lits("AAAA"); push_done();
        send_str("AAAA"); drain();

        push_lits("abcdefghijklabc"); push_done();
        send_str("abcdefghijklabc"); drain();

        hold = 1'b1;
        push_lits("XY"); push_done();
        send_str("XY");
        wait_valid();
        d0 = data_out;
        l0 = literal;
        chk("stall_first_data", d0, 24'h58);
        repeat (5) begin
            @(negedge clk);
            chk("stall_valid", token_valid, 1);
            chk("stall_data", data_out, d0);
            chk("stall_literal", literal, l0);
            chk("stall_in_ready", in_ready, 0);
        end
        hold = 1'b0;
        drain();

        hold = 1'b1;
        send_str("ABCX");
        wait_valid();
        @(negedge clk);
        #2 rst_ = 1'b0;
        #1 chk_idle("reset_in_emit");
        exp_q.delete();
        release_reset();

        send_str("PQ");
        @(posedge clk);
        #2 rst_ = 1'b0;
        #1 chk_idle("reset_in_search");
        exp_q.delete();
        release_reset();
        hold = 1'b0;
        push_lits("AB"); push_done();
        send_str("AB"); drain();

        repeat (30) begin
            logic [7:0] q[$];
            int n, a;
            n = $urandom_range(1, 40);
            a = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                q.push_back(8'(8'h41 + $urandom_range(0, a - 1)));
            model(q);
            send(q);
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/lzss_encoder.md
LZSS_ENCODER -- requirements
Module: lzss_encoder

Interface
REQ-001 SHALL use package parameters: SYMBOL_LENGTH, default 8, symbol width; SEARCH_BUFFER_SIZE, default 8, history depth in symbols.
REQ-002 SHALL have local parameter LOOKAHEAD_SIZE, default 16, lookahead depth; range 1..255.
REQ-003 SHALL have local parameter MIN_MATCH, default 3, shortest match emitted as a reference.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 rst_  in  1  reset, asynchronous and active-low.
REQ-006 sym_in  in  SYMBOL_LENGTH  uncompressed input symbol.
REQ-007 sym_valid  in  1  sym_in is valid.
REQ-008 sym_last  in  1  qualifies sym_in as the final symbol of the stream.
REQ-009 in_ready  out  1  encoder accepts sym_in this cycle.
REQ-010 token_valid  out  1  data_out/literal hold a token.
REQ-011 token_ready  in  1  downstream decoder consumes the token.
REQ-012 literal  out  1  1 = literal token, 0 = match token.
REQ-013 data_out  out  3*SYMBOL_LENGTH  literal: [7:0] symbol, rest 0; match: [15:0] offset, [23:16] length.
REQ-014 done  out  1  one-cycle pulse after the final token of a stream is consumed.

Function
REQ-015 Transfers SHALL occur on sym_valid&in_ready (input) and token_valid&token_ready (output) at a rising edge.
REQ-016 FSM states SHALL be FILL, SEARCH, EMIT, SHIFT, DONE; reset state FILL.
REQ-017 FILL: in_ready=1 while lookahead count < LOOKAHEAD_SIZE and no sym_last accepted; accepted symbols append to lookahead tail.
REQ-018 FILL -> SEARCH when count == LOOKAHEAD_SIZE, or last seen and count > 0; FILL -> DONE when last seen and count == 0.
REQ-019 in_ready SHALL be 0 in every state other than FILL.
REQ-020 History: entry 0 = most recently encoded symbol; hist_count saturates at SEARCH_BUFFER_SIZE; the oldest entry is discarded when full.
REQ-021 SEARCH examines one offset per cycle, 0 to hist_count-1; with hist_count == 0, SEARCH lasts one cycle and finds no match.
REQ-022 Match length at offset d counts equal leading symbols between the lookahead and history entries d, d-1, ..., 0.
REQ-023 Match length is capped at min(d+1, lookahead count, 255); no overlap into the lookahead.
REQ-024 Best match: longest wins; ties keep the smaller offset (update only on strictly greater).
REQ-025 EMIT: if best length >= MIN_MATCH, token is literal=0, data_out = {length[7:0], offset[15:0]}.
REQ-026 EMIT otherwise: literal=1, data_out = {16'h0, lookahead head}, consumed length = 1.
REQ-027 token_valid=1 only in EMIT; data_out and literal stay stable until the token is consumed.
REQ-028 On the token transfer, SHALL go to SHIFT.
REQ-029 SHIFT moves one lookahead head symbol per cycle into history entry 0 (older entries shift up) for consumed-length cycles, then returns to FILL.
REQ-030 DONE: done=1 for exactly one cycle, end-of-stream flag cleared, history cleared, -> FILL.

Reset
REQ-031 rst_ low SHALL immediately force: state FILL, counts 0, in_ready 0, token_valid 0, literal 0, data_out 0, done 0.
REQ-032 in_ready SHALL rise on the first edge after rst_ deasserts.
REQ-033 Reset during any state SHALL abandon the pending token with no partial output afterwards.

Verification
REQ-034 Input "ABC" with last on C, token_ready=1 -> three literal tokens, data_out 0x000041, 0x000042, 0x000043, then done pulse.
REQ-035 Input "ABCABC" with last -> literals A,B,C, then match literal=0 data_out=0x030002, then done.
REQ-036 Input "AAAA" with last -> four literal tokens 0x41; overlap cap prevents a match.
REQ-037 Token pending with token_ready=0 for 5 cycles -> token_valid=1, data_out/literal unchanged, in_ready=0 throughout.
REQ-038 rst_ pulsed low mid-SEARCH -> outputs 0 asynchronously; the next stream "AB" yields literals 0x41, 0x42 (history empty).
REQ-039 Stream of SEARCH_BUFFER_SIZE+4 distinct symbols, then repeat of the first 3 -> all literals.
REQ-040 REQ-039 check: the evicted symbols are never referenced by a match.
